// File: rtl/wb_assoc_cache.sv
// N-way set-associative write-back, write-allocate line cache between a Wishbone
// requester (sb_*) and a Wishbone memory port (wb_*), with tree-PLRU replacement.
module wb_assoc_cache #(
  parameter int WAYS      = 2,
  parameter int SETS      = 8,
  parameter int LINE_BITS = 128,
  parameter int ADDR_W    = 12,
  parameter int CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sb_cyc,
  input  logic                   sb_stb,
  input  logic                   sb_we,
  input  logic [LINE_BITS/8-1:0] sb_sel,
  input  logic [ADDR_W-1:0]      sb_adr,
  input  logic [LINE_BITS-1:0]   sb_dat_m,
  output logic [LINE_BITS-1:0]   sb_dat_s,
  output logic                   sb_ack,
  output logic                   wb_cyc,
  output logic                   wb_stb,
  output logic                   wb_we,
  output logic [LINE_BITS/8-1:0] wb_sel,
  output logic [ADDR_W-1:0]      wb_adr,
  output logic [LINE_BITS-1:0]   wb_dat_m,
  input  logic [LINE_BITS-1:0]   wb_dat_s,
  input  logic                   wb_ack,
  output logic [CNT_W-1:0]       hit_count,
  output logic [CNT_W-1:0]       miss_count
);
  localparam int IDX   = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX;
  localparam int WW    = $clog2(WAYS);

  typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} state_t;
  state_t state;

  logic [ADDR_W-1:0]      lat_adr;
  logic                   lat_we;
  logic [LINE_BITS/8-1:0] lat_sel;
  logic [LINE_BITS-1:0]   lat_dat;
  logic                   first_look;
  logic [WW-1:0]          victim;

  logic [TAG_W-1:0]     tag_arr  [WAYS][SETS];
  logic [LINE_BITS-1:0] data_arr [WAYS][SETS];
  logic [SETS-1:0]      valid    [WAYS];
  logic [SETS-1:0]      dirty    [WAYS];
  // bit 0 = root (1 -> right half is LRU), bit 1 = left pair, bit 2 = right pair;
  // a 2-way cache only uses bit 0, which names the LRU way directly
  logic [2:0]           plru     [SETS];

  logic [IDX-1:0]       idx;
  logic [TAG_W-1:0]     tag;
  logic                 hit, has_inv;
  logic [WW-1:0]        hit_way, inv_way, miss_way;
  logic [LINE_BITS-1:0] hit_line, merged;

  function automatic logic [WW-1:0] plru_victim(input logic [2:0] p);
    logic [1:0] v4;
    v4 = p[0] ? {1'b1, p[2]} : {1'b0, p[1]};
    return (WAYS == 2) ? WW'(p[0]) : WW'(v4);
  endfunction

  function automatic logic [2:0] plru_touch(input logic [2:0] p, input logic [1:0] w);
    logic [2:0] np;
    np = p;
    if (WAYS == 2) begin
      np[0] = ~w[0];
    end else begin
      np[0] = ~w[1];
      if (w[1]) np[2] = ~w[0];
      else      np[1] = ~w[0];
    end
    return np;
  endfunction

  assign idx = lat_adr[IDX-1:0];
  assign tag = lat_adr[ADDR_W-1:IDX];

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    has_inv = 1'b0;
    inv_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && valid[w][idx] && tag_arr[w][idx] == tag) begin
        hit     = 1'b1;
        hit_way = WW'(w);
      end
      if (!has_inv && !valid[w][idx]) begin
        has_inv = 1'b1;
        inv_way = WW'(w);
      end
    end
    miss_way = has_inv ? inv_way : plru_victim(plru[idx]);
    hit_line = data_arr[hit_way][idx];
    merged   = hit_line;
    for (int b = 0; b < LINE_BITS/8; b++)
      if (lat_sel[b]) merged[b*8 +: 8] = lat_dat[b*8 +: 8];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sb_ack     <= 1'b0;
      sb_dat_s   <= '0;
      wb_cyc     <= 1'b0;
      wb_stb     <= 1'b0;
      wb_we      <= 1'b0;
      wb_sel     <= '0;
      wb_adr     <= '0;
      wb_dat_m   <= '0;
      hit_count  <= '0;
      miss_count <= '0;
      lat_adr    <= '0;
      lat_we     <= 1'b0;
      lat_sel    <= '0;
      lat_dat    <= '0;
      first_look <= 1'b0;
      victim     <= '0;
      for (int w = 0; w < WAYS; w++) begin
        valid[w] <= '0;
        dirty[w] <= '0;
      end
      for (int s = 0; s < SETS; s++) plru[s] <= '0;
    end else begin
      sb_ack   <= 1'b0;
      sb_dat_s <= '0;
      case (state)
        IDLE: begin
          // sb_ack still high means the requester is holding the strobe of the finished request
          if (sb_cyc && sb_stb && !sb_ack) begin
            lat_adr    <= sb_adr;
            lat_we     <= sb_we;
            lat_sel    <= sb_sel;
            lat_dat    <= sb_dat_m;
            first_look <= 1'b1;
            state      <= COMPARE;
          end
        end
        COMPARE: begin
          if (hit) begin
            sb_ack    <= 1'b1;
            sb_dat_s  <= lat_we ? merged : hit_line;
            plru[idx] <= plru_touch(plru[idx], 2'(hit_way));
            if (lat_we) begin
              data_arr[hit_way][idx] <= merged;
              dirty[hit_way][idx]    <= 1'b1;
            end
            if (first_look && hit_count != '1) hit_count <= hit_count + 1'b1;
            state <= IDLE;
          end else begin
            if (miss_count != '1) miss_count <= miss_count + 1'b1;
            first_look <= 1'b0;
            victim     <= miss_way;
            wb_cyc     <= 1'b1;
            wb_stb     <= 1'b1;
            wb_sel     <= '1;
            if (valid[miss_way][idx] && dirty[miss_way][idx]) begin
              wb_we    <= 1'b1;
              wb_adr   <= {tag_arr[miss_way][idx], idx};
              wb_dat_m <= data_arr[miss_way][idx];
              state    <= WRITEBACK;
            end else begin
              wb_we    <= 1'b0;
              wb_adr   <= lat_adr;
              wb_dat_m <= '0;
              state    <= ALLOCATE;
            end
          end
        end
        WRITEBACK: begin
          if (wb_ack) begin
            dirty[victim][idx] <= 1'b0;
            wb_we    <= 1'b0;
            wb_adr   <= lat_adr;
            wb_dat_m <= '0;
            state    <= ALLOCATE;
          end
        end
        ALLOCATE: begin
          // the refilled line is re-examined in COMPARE, where it now hits
          if (wb_ack) begin
            data_arr[victim][idx] <= wb_dat_s;
            tag_arr[victim][idx]  <= tag;
            valid[victim][idx]    <= 1'b1;
            dirty[victim][idx]    <= 1'b0;
            wb_cyc   <= 1'b0;
            wb_stb   <= 1'b0;
            wb_sel   <= '0;
            wb_adr   <= '0;
            state    <= COMPARE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_assoc_cache.sv
// Bench for wb_assoc_cache (2-way, 8 sets): directed vector table, multi-cycle corner
// sequences, and random traffic checked against an LRU-list plus flat-memory model.
module tb_wb_assoc_cache;
  localparam int CNT_W = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sb_cyc = 1'b0, sb_stb = 1'b0, sb_we = 1'b0;
  logic [15:0] sb_sel = '0;
  logic [11:0] sb_adr = '0;
  logic [127:0] sb_dat_m = '0;
  logic [127:0] sb_dat_s;
  logic sb_ack;
  logic wb_cyc, wb_stb, wb_we;
  logic [15:0] wb_sel;
  logic [11:0] wb_adr;
  logic [127:0] wb_dat_m;
  logic [127:0] wb_dat_s = '0;
  logic wb_ack = 1'b0;
  logic [CNT_W-1:0] hit_count, miss_count;

  wb_assoc_cache #(.WAYS(2), .SETS(8), .LINE_BITS(128), .ADDR_W(12), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .sb_cyc(sb_cyc), .sb_stb(sb_stb), .sb_we(sb_we), .sb_sel(sb_sel), .sb_adr(sb_adr),
    .sb_dat_m(sb_dat_m), .sb_dat_s(sb_dat_s), .sb_ack(sb_ack),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_sel(wb_sel), .wb_adr(wb_adr),
    .wb_dat_m(wb_dat_m), .wb_dat_s(wb_dat_s), .wb_ack(wb_ack),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] init_line(input logic [11:0] a);
    return (a == 12'h010) ? {8{16'hAAAA}} : {8{4'hC, a}};
  endfunction

  // memory model on the wb side
  logic [127:0] mem [4096];
  int mem_delay = 0, dcnt = 0, wb_cnt = 0, fill_cnt = 0;
  logic [11:0] last_wb_adr = '0;
  logic [127:0] last_wb_dat = '0;

  always begin
    @(posedge clk); #1;
    if (wb_ack) begin
      wb_ack = 1'b0;
      wb_dat_s = '0;
      dcnt = 0;
    end else if (wb_cyc && wb_stb && !rst) begin
      if (dcnt >= mem_delay) begin
        check("wb_sel", 128'(wb_sel), 128'(16'hFFFF));
        wb_ack = 1'b1;
        dcnt = 0;
        if (wb_we) begin
          mem[wb_adr] = wb_dat_m;
          wb_cnt++;
          last_wb_adr = wb_adr;
          last_wb_dat = wb_dat_m;
        end else begin
          wb_dat_s = mem[wb_adr];
          fill_cnt++;
        end
      end else begin
        dcnt++;
      end
    end else begin
      dcnt = 0;
    end
  end

  // scoreboard
  logic [127:0] exp_q[$];

  // driver: holds the strobe through the ack cycle, then drops it
  task automatic do_txn(input logic we, input logic [11:0] adr, input logic [15:0] sel,
                        input logic [127:0] dat, output logic [127:0] rdata, output int lat);
    bit got;
    got = 1'b0;
    rdata = '0;
    lat = 0;
    sb_cyc = 1'b1; sb_stb = 1'b1; sb_we = we; sb_adr = adr; sb_sel = sel; sb_dat_m = dat;
    while (!got && lat < 300) begin
      @(posedge clk); #1;
      lat++;
      if (sb_ack) begin
        got = 1'b1;
        rdata = sb_dat_s;
      end
    end
    check("txn_ack", 128'(got), 128'(1));
    @(posedge clk); #1;
    sb_cyc = 1'b0; sb_stb = 1'b0; sb_we = 1'b0; sb_sel = '0; sb_dat_m = '0;
  endtask

  task automatic run_check(input string nm, input logic we, input logic [11:0] adr,
                           input logic [15:0] sel, input logic [127:0] dat, input logic exp_hit,
                           input logic [127:0] exp_dat, input int exp_wb,
                           input logic [11:0] exp_wb_adr, input logic [127:0] exp_wb_dat,
                           input int exp_fill);
    int h0, m0, lat;
    logic [127:0] rd;
    h0 = int'(hit_count);
    m0 = int'(miss_count);
    wb_cnt = 0;
    fill_cnt = 0;
    if (!we) exp_q.push_back(exp_dat);
    do_txn(we, adr, sel, dat, rd, lat);
    check({nm, "_hit_inc"}, 128'(int'(hit_count) - h0), 128'(exp_hit));
    check({nm, "_miss_inc"}, 128'(int'(miss_count) - m0), 128'(!exp_hit));
    check({nm, "_wb_cnt"}, 128'(wb_cnt), 128'(exp_wb));
    check({nm, "_fill_cnt"}, 128'(fill_cnt), 128'(exp_fill));
    if (exp_wb > 0) begin
      check({nm, "_wb_adr"}, 128'(last_wb_adr), 128'(exp_wb_adr));
      check({nm, "_wb_dat"}, last_wb_dat, exp_wb_dat);
    end
    if (!we) check({nm, "_rdata"}, rd, exp_q.pop_front());
    if (exp_hit) check({nm, "_latency"}, 128'(lat), 128'(2));
  endtask

  typedef struct {
    logic         we;
    logic [11:0]  adr;
    logic [15:0]  sel;
    logic [127:0] dat;
    logic         exp_hit;
    logic [127:0] exp_dat;
    int           exp_wb;
    logic [11:0]  exp_wb_adr;
    logic [127:0] exp_wb_dat;
    int           exp_fill;
  } vec_t;
  vec_t vecs[9];

  // reference model: per-set LRU list of tags plus a flat view of memory as reads see it
  logic [127:0] ref_mem [4096];
  bit           ref_dirty [4096];
  logic [8:0]   ref_q [8][$];

  initial begin
    logic [127:0] la, m1, m2, d1, d2, rd;
    logic [11:0] a, ea;
    logic [8:0] tg, ev;
    logic [2:0] s;
    logic we;
    logic [15:0] sel;
    logic [127:0] dat, exp_dat, exp_wb_dat;
    logic hitm;
    int exp_wb, lat, cyc_cycles, m0;
    bit got, stable_ok, early;

    for (int i = 0; i < 4096; i++) mem[i] = init_line(12'(i));

    la = {8{16'hAAAA}};
    d1 = {{7{16'h1234}}, 16'hBEEF};
    m1 = {la[127:16], 16'hBEEF};
    d2 = {16{8'h11}};
    m2 = {8'h11, m1[119:0]};
    vecs[0] = '{we:0, adr:12'h010, sel:16'h0,    dat:'0, exp_hit:0, exp_dat:la,  exp_wb:0, exp_wb_adr:'0,     exp_wb_dat:'0, exp_fill:1};
    vecs[1] = '{we:0, adr:12'h010, sel:16'h0,    dat:'0, exp_hit:1, exp_dat:la,  exp_wb:0, exp_wb_adr:'0,     exp_wb_dat:'0, exp_fill:0};
    vecs[2] = '{we:1, adr:12'h010, sel:16'h0003, dat:d1, exp_hit:1, exp_dat:'0,  exp_wb:0, exp_wb_adr:'0,     exp_wb_dat:'0, exp_fill:0};
    vecs[3] = '{we:0, adr:12'h010, sel:16'h0,    dat:'0, exp_hit:1, exp_dat:m1,  exp_wb:0, exp_wb_adr:'0,     exp_wb_dat:'0, exp_fill:0};
    vecs[4] = '{we:0, adr:12'h018, sel:16'h0,    dat:'0, exp_hit:0, exp_dat:init_line(12'h018), exp_wb:0, exp_wb_adr:'0, exp_wb_dat:'0, exp_fill:1};
    vecs[5] = '{we:1, adr:12'h010, sel:16'h8000, dat:d2, exp_hit:1, exp_dat:'0,  exp_wb:0, exp_wb_adr:'0,     exp_wb_dat:'0, exp_fill:0};
    vecs[6] = '{we:0, adr:12'h018, sel:16'h0,    dat:'0, exp_hit:1, exp_dat:init_line(12'h018), exp_wb:0, exp_wb_adr:'0, exp_wb_dat:'0, exp_fill:0};
    vecs[7] = '{we:0, adr:12'h020, sel:16'h0,    dat:'0, exp_hit:0, exp_dat:init_line(12'h020), exp_wb:1, exp_wb_adr:12'h010, exp_wb_dat:m2, exp_fill:1};
    vecs[8] = '{we:0, adr:12'h010, sel:16'h0,    dat:'0, exp_hit:0, exp_dat:m2,  exp_wb:0, exp_wb_adr:'0,     exp_wb_dat:'0, exp_fill:1};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_sb_ack", 128'(sb_ack), 128'(0));
    check("rst_sb_dat_s", sb_dat_s, '0);
    check("rst_wb_ctl", 128'({wb_cyc, wb_stb, wb_we, wb_sel}), 128'(0));
    check("rst_wb_adr_dat", {wb_dat_m[115:0], wb_adr}, '0);
    check("rst_counts", 128'({hit_count, miss_count}), 128'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++)
      run_check($sformatf("vec%0d", i), vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].dat,
                vecs[i].exp_hit, vecs[i].exp_dat, vecs[i].exp_wb, vecs[i].exp_wb_adr,
                vecs[i].exp_wb_dat, vecs[i].exp_fill);

    // slow fill: request must sit stable and the requester must not see an ack early
    mem_delay = 5;
    cyc_cycles = 0; stable_ok = 1'b1; early = 1'b0; got = 1'b0; rd = '0;
    sb_cyc = 1'b1; sb_stb = 1'b1; sb_we = 1'b0; sb_adr = 12'h031;
    for (int c = 0; c < 60 && !got; c++) begin
      @(posedge clk); #1;
      if (wb_cyc) begin
        cyc_cycles++;
        if (wb_adr != 12'h031 || wb_we) stable_ok = 1'b0;
        if (sb_ack) early = 1'b1;
      end
      if (sb_ack) begin
        got = 1'b1;
        rd = sb_dat_s;
      end
    end
    check("slow_ack", 128'(got), 128'(1));
    check("slow_stable", 128'(stable_ok), 128'(1));
    check("slow_early_ack", 128'(early), 128'(0));
    check("slow_cyc_cycles", 128'(cyc_cycles), 128'(6));
    check("slow_rdata", rd, init_line(12'h031));
    @(posedge clk); #1;
    sb_cyc = 1'b0; sb_stb = 1'b0;
    mem_delay = 0;

    // reset while a writeback is outstanding
    run_check("wbr_a", 1, 12'h0A2, 16'hFFFF, {4{32'h0BADF00D}}, 0, '0, 0, '0, '0, 1);
    run_check("wbr_b", 1, 12'h0B2, 16'hFFFF, {4{32'h0BADF00D}}, 0, '0, 0, '0, '0, 1);
    mem_delay = 20;
    got = 1'b0;
    sb_cyc = 1'b1; sb_stb = 1'b1; sb_we = 1'b0; sb_adr = 12'h0C2;
    for (int c = 0; c < 50 && !got; c++) begin
      @(posedge clk); #1;
      if (wb_cyc && wb_we) got = 1'b1;
    end
    check("wbr_reached", 128'(got), 128'(1));
    check("wbr_victim_adr", 128'(wb_adr), 128'(12'h0A2));
    rst = 1'b1; sb_cyc = 1'b0; sb_stb = 1'b0;
    @(posedge clk); #1;
    check("wbr_cyc_after_rst", 128'({wb_cyc, wb_stb}), 128'(0));
    check("wbr_ack_after_rst", 128'(sb_ack), 128'(0));
    check("wbr_counts_after_rst", 128'({hit_count, miss_count}), 128'(0));
    rst = 1'b0;
    mem_delay = 0;
    @(posedge clk); #1;
    run_check("wbr_reread", 0, 12'h010, 16'h0, '0, 0, m2, 0, '0, '0, 1);
    run_check("wbr_lost_a", 0, 12'h0A2, 16'h0, '0, 0, init_line(12'h0A2), 0, '0, '0, 1);

    // random traffic from a clean cache
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4096; i++) begin
      ref_mem[i] = mem[i];
      ref_dirty[i] = 1'b0;
    end
    for (int i = 0; i < 8; i++) ref_q[i].delete();
    for (int t = 0; t < 300; t++) begin
      s = 3'($urandom_range(0, 3));
      tg = 9'($urandom_range(0, 5));
      a = {tg, s};
      we = 1'($urandom_range(0, 1));
      sel = 16'($urandom);
      dat = {$urandom, $urandom, $urandom, $urandom};
      mem_delay = $urandom_range(0, 3);
      hitm = 1'b0;
      exp_wb = 0;
      ea = '0;
      exp_wb_dat = '0;
      for (int k = 0; k < ref_q[s].size(); k++)
        if (!hitm && ref_q[s][k] == tg) begin
          hitm = 1'b1;
          ref_q[s].delete(k);
        end
      if (!hitm && ref_q[s].size() == 2) begin
        ev = ref_q[s].pop_front();
        ea = {ev, s};
        if (ref_dirty[ea]) begin
          exp_wb = 1;
          exp_wb_dat = ref_mem[ea];
          ref_dirty[ea] = 1'b0;
        end
      end
      ref_q[s].push_back(tg);
      exp_dat = ref_mem[a];
      if (we) begin
        for (int b = 0; b < 16; b++)
          if (sel[b]) ref_mem[a][b*8 +: 8] = dat[b*8 +: 8];
        ref_dirty[a] = 1'b1;
      end
      run_check($sformatf("rnd%0d", t), we, a, sel, dat, hitm, exp_dat, exp_wb, ea,
                exp_wb_dat, hitm ? 0 : 1);
    end
    mem_delay = 0;

    // hit counter saturation
    do_txn(1'b0, 12'h005, 16'h0, '0, rd, lat);
    m0 = int'(miss_count);
    for (int i = 0; i < (1 << CNT_W) + 4; i++) do_txn(1'b0, 12'h005, 16'h0, '0, rd, lat);
    check("sat_hit_count", 128'(hit_count), 128'({CNT_W{1'b1}}));
    check("sat_miss_unchanged", 128'(miss_count), 128'(m0));
    do_txn(1'b0, 12'h005, 16'h0, '0, rd, lat);
    check("sat_no_wrap", 128'(hit_count), 128'({CNT_W{1'b1}}));
    check("sat_rdata", rd, init_line(12'h005));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end
endmodule
